// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide, one bit per cycle.
// Optional build macro MULDIV_FAST_MUL_EN selects a single-cycle combinational multiplier for MUL* ops.
module muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [XLEN-1:0]  in_a,
  input  logic [XLEN-1:0]  in_b,
  input  logic [TAG_W-1:0] in_rd,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic [TAG_W-1:0] out_rd
);
  localparam int               CNT_W    = $clog2(XLEN + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN);
  localparam logic [XLEN-1:0]  MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             early_q, early_d;
  logic [XLEN-1:0]  result_q, result_d;
  logic [TAG_W-1:0] out_rd_q, out_rd_d;
  logic [2:0]       op_q, op_d;
  logic [TAG_W-1:0] rd_q, rd_d;
  logic             neg_q, neg_d;
  logic             rneg_q, rneg_d;
  logic [XLEN-1:0]  hi_q, hi_d, lo_q, lo_d, opnd_q, opnd_d;

  logic             accept, finish;
  logic             is_div, a_signed, b_signed, a_neg, b_neg, div_zero, div_ovf;
  logic [XLEN-1:0]  mag_a, mag_b, early_res, fin_res;
  logic [2*XLEN-1:0] prod;
  logic [XLEN:0]    mul_sum, div_shift, div_diff;
`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] fast_prod;
  logic [XLEN-1:0]   fast_res;
`endif

  function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  function automatic logic [2*XLEN-1:0] cond_neg2(input logic [2*XLEN-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (accept) state_d = S_BUSY;
      S_BUSY:  if (finish) state_d = S_DONE;
      S_DONE:  if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == S_IDLE);
    out_valid = (state_q == S_DONE);
  end

  assign accept     = in_valid & in_ready;
  assign finish     = early_q | (count_q == CNT_LAST);
  assign out_result = result_q;
  assign out_rd     = out_rd_q;

  // Magnitudes, sign flags and the cases that bypass iteration
  always_comb begin
    is_div   = in_op[2];
    a_signed = is_div ? ~in_op[0] : ((in_op[1:0] == 2'b01) || (in_op[1:0] == 2'b10));
    b_signed = is_div ? ~in_op[0] : (in_op[1:0] == 2'b01);
    a_neg    = a_signed & in_a[XLEN-1];
    b_neg    = b_signed & in_b[XLEN-1];
    mag_a    = cond_neg(in_a, a_neg);
    mag_b    = cond_neg(in_b, b_neg);
    div_zero = is_div && (in_b == '0);
    div_ovf  = is_div && !in_op[0] && (in_a == MIN_NEG) && (in_b == '1);
    if (div_zero) early_res = in_op[1] ? in_a : '1;
    else          early_res = in_op[1] ? '0 : in_a;
`ifdef MULDIV_FAST_MUL_EN
    fast_prod = cond_neg2({{XLEN{1'b0}}, mag_a} * {{XLEN{1'b0}}, mag_b}, a_neg ^ b_neg);
    fast_res  = (in_op[1:0] == 2'b00) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
`endif
  end

  // One iteration step and the final sign fixup
  always_comb begin
    mul_sum   = {1'b0, hi_q} + {1'b0, {XLEN{lo_q[0]}} & opnd_q};
    div_shift = {hi_q, lo_q[XLEN-1]};
    div_diff  = div_shift - {1'b0, opnd_q};
    prod      = cond_neg2({hi_q, lo_q}, neg_q);
    if (early_q)       fin_res = lo_q;
    else if (!op_q[2]) fin_res = (op_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    else if (op_q[1])  fin_res = cond_neg(hi_q, rneg_q);
    else               fin_res = cond_neg(lo_q, neg_q);
  end

  always_comb begin
    count_d  = count_q;
    early_d  = early_q;
    result_d = result_q;
    out_rd_d = out_rd_q;
    op_d     = op_q;
    rd_d     = rd_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    opnd_d   = opnd_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d    = in_op;
          rd_d    = in_rd;
          count_d = '0;
          neg_d   = a_neg ^ b_neg;
          rneg_d  = a_neg;
          early_d = div_zero | div_ovf;
          hi_d    = '0;
          // Multiply: lo holds the multiplier; divide: lo holds the dividend/quotient
          lo_d    = is_div ? mag_a : mag_b;
          opnd_d  = is_div ? mag_b : mag_a;
          if (div_zero | div_ovf) lo_d = early_res;
`ifdef MULDIV_FAST_MUL_EN
          if (!is_div) begin
            early_d = 1'b1;
            lo_d    = fast_res;
          end
`endif
        end
      end
      S_BUSY: begin
        if (finish) begin
          result_d = fin_res;
          out_rd_d = rd_q;
        end else begin
          count_d = count_q + CNT_W'(1);
          if (op_q[2]) begin
            hi_d = div_diff[XLEN] ? div_shift[XLEN-1:0] : div_diff[XLEN-1:0];
            lo_d = {lo_q[XLEN-2:0], ~div_diff[XLEN]};
          end else begin
            {hi_d, lo_d} = {mul_sum, lo_q[XLEN-1:1]};
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q  <= '0;
      early_q  <= 1'b0;
      result_q <= '0;
      out_rd_q <= '0;
    end else begin
      count_q  <= count_d;
      early_q  <= early_d;
      result_q <= result_d;
      out_rd_q <= out_rd_d;
    end
  end

  always_ff @(posedge clk) begin
    op_q   <= op_d;
    rd_q   <= rd_d;
    neg_q  <= neg_d;
    rneg_q <= rneg_d;
    hi_q   <= hi_d;
    lo_q   <= lo_d;
    opnd_q <= opnd_d;
  end
endmodule
